dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
//  Memory-side responder for the core's load/store port: accepts one request at a time over a
//  valid/ready channel and returns a response over a valid/ready channel after programmable
//  wait states. Replaces the zero-latency data memory so the pipeline can be run against
//  realistic latency and backpressure.
//  Sits between the core's EX/MEM memory access and the word-addressed storage array.
// PARAMETERS
//  DEPTH    1024  storage size in 32-bit words (power of two, >= 4)
//  LATENCY  2     wait-state cycles between accept and response (0..15)
// PORTS
//  clk          in   1   single clock, all logic on posedge
//  rst          in   1   reset, asynchronous, active-high
//  req_valid_i  in   1   request valid
//  req_ready_o  out  1   responder can accept request
//  req_we_i     in   1   1 = store, 0 = load
//  req_addr_i   in   32  byte address
//  req_wdata_i  in   32  store data
//  req_be_i     in   4   store byte enables, bit n -> byte n (bits 8n+7:8n)
//  rsp_valid_o  out  1   response valid
//  rsp_ready_i  in   1   consumer accepts response
//  rsp_rdata_o  out  32  load data (0 for stores and errors)
//  rsp_err_o    out  1   access error
// BEHAVIOUR
//  Reset, async on rst=1: state=IDLE; req_ready_o=1; rsp_valid_o=0; rsp_rdata_o=0; rsp_err_o=0.
//    Wait counter=0. Storage contents not reset.
//  FSM IDLE -> WAIT -> RESP -> IDLE. req_ready_o=1 only in IDLE (registered, from state).
//  IDLE: on req_valid_i&req_ready_o, capture we/addr/wdata/be.
//    Goes to WAIT (LATENCY>0) or RESP (LATENCY==0).
//  WAIT: counter loads LATENCY-1 on accept, decrements each cycle; at 0 -> RESP.
//  Commit edge (entry to RESP): store writes enabled bytes; load registers word into rsp_rdata_o.
//  Accept-to-rsp_valid_o latency = 1+LATENCY cycles; max throughput 1 per 2+LATENCY cycles.
//  RESP: rsp_valid_o=1; rdata/err held stable until rsp_ready_i=1.
//    On that edge -> IDLE, rsp_valid_o=0. No new accept in the same cycle.
//  Index = req_addr_i[$clog2(DEPTH)+1:2].
//  Error if addr[1:0]!=0 or addr>=4*DEPTH: no write, rdata=0, err=1, same latency.
//  Store with be=4'b0000 is a legal no-op response (err=0). rsp_rdata_o=0 for every store.
//  Requests while not IDLE are ignored; requester must hold them until req_ready_o.
//  rst mid-operation: transaction dropped, no response; store lost if commit edge not reached.
// CONFIGURATION
//  DMEM_RSP_PERF_EN defined: adds outputs rd_cnt_o, wr_cnt_o, err_cnt_o, each 32 bits, reset 0.
//    Each counter increments on the response handshake edge: load ok, store ok, error.
//    Counters wrap mod 2^32.
//  Not defined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  dmem_pkg: typedef enum logic [1:0] {IDLE,WAIT,RESP} dmem_state_e; XLEN=32; BE_W=4;
//    dmem_req_t struct {we,addr,wdata,be}.
//  Sub-module dmem_array: DEPTH x 32 storage, sync byte-enabled write, sync read, one port.
//    Instantiated once; FSM, counter, error check and response regs stay in dmem_responder.
// TESTING
//  1 LATENCY=2: store addr 0x10 data 0xDEADBEEF be 1111 -> rsp_valid 3 cycles after accept, err 0;
//    then load 0x10 -> rdata 0xDEADBEEF.
//  2 Store 0x10 data 0x000000AA be 0001 over 0xDEADBEEF -> load 0x10 returns 0xDEADBEAA.
//  3 Load addr 0x13 -> err=1, rdata=0; store to 4*DEPTH -> err=1, memory unchanged on reread.
//  4 rsp_ready_i held 0 for 5 cycles -> rsp_valid/rdata stable, req_ready_o=0 throughout;
//    release -> IDLE next cycle.
//  5 LATENCY=0: load accepted at cycle N -> rsp_valid at N+1; back-to-back loads, one per 2 cycles.
//  6 rst pulsed in WAIT of store to 0x20 -> no response, req_ready_o=1, 0x20 keeps old value;
//    PERF_EN counters read 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Used by dmem_array and dmem_responder.
package dmem_pkg;

    localparam int XLEN = 32;
    localparam int BE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [BE_W-1:0] be;
    } dmem_req_t;

    // A request faults when it is not word aligned or lies past the end of storage.
    function automatic logic addr_error(input logic [XLEN-1:0] addr, input int depth);
        logic [XLEN:0] limit;
        limit = 33'(depth) << 2;
        return (addr[1:0] != 2'b00) || ({1'b0, addr} >= limit);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed DEPTH x 32 storage with one synchronous port.
// Byte lanes are separate arrays so each maps onto a plain block RAM with a registered read.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            en,
    input  logic            we,
    input  logic [BE_W-1:0] be,
    input  logic [AW-1:0]   addr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata
);

    for (genvar gi = 0; gi < BE_W; gi++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] q_reg;

        always_ff @(posedge clk) begin
            if (en) begin
                if (we) begin
                    if (be[gi]) begin
                        mem[addr] <= wdata[8*gi +: 8];
                    end
                end else begin
                    q_reg <= mem[addr];
                end
            end
        end

        assign rdata[8*gi +: 8] = q_reg;
    end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side load/store responder with programmable wait states and valid/ready channels.
// Optional performance counters are enabled with DMEM_RSP_PERF_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_we_i,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [XLEN-1:0] req_wdata_i,
    input  logic [BE_W-1:0] req_be_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [XLEN-1:0] rsp_rdata_o,
    output logic            rsp_err_o
`ifdef DMEM_RSP_PERF_EN
    ,
    output logic [XLEN-1:0] rd_cnt_o,
    output logic [XLEN-1:0] wr_cnt_o,
    output logic [XLEN-1:0] err_cnt_o
`endif
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = 4;

    dmem_state_e      state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             we_reg;
    logic [AW-1:0]    idx_reg;
    logic [XLEN-1:0]  wdata_reg;
    logic [BE_W-1:0]  be_reg;
    logic             req_err_reg;
    logic             rsp_err_reg;
    logic             load_ok_reg;

    dmem_req_t        req_in;
    logic             req_in_err;
    logic             accept;
    logic             rsp_fire;
    logic             commit;
    logic             commit_we;
    logic             commit_err;
    logic [AW-1:0]    commit_idx;
    logic [XLEN-1:0]  commit_wdata;
    logic [BE_W-1:0]  commit_be;
    logic [XLEN-1:0]  ram_q;

    assign req_in     = '{we: req_we_i, addr: req_addr_i, wdata: req_wdata_i, be: req_be_i};
    assign req_in_err = addr_error(req_in.addr, DEPTH);
    assign accept     = (state_reg == IDLE) && req_valid_i;
    assign rsp_fire   = (state_reg == RESP) && rsp_ready_i;

    // With no wait states the commit edge is the accept edge, so the array is fed straight from the request.
    always_comb begin
        commit       = 1'b0;
        commit_we    = we_reg;
        commit_err   = req_err_reg;
        commit_idx   = idx_reg;
        commit_wdata = wdata_reg;
        commit_be    = be_reg;
        if (LATENCY == 0) begin
            commit       = accept;
            commit_we    = req_in.we;
            commit_err   = req_in_err;
            commit_idx   = req_in.addr[AW+1:2];
            commit_wdata = req_in.wdata;
            commit_be    = req_in.be;
        end else begin
            commit = (state_reg == WAIT) && (cnt_reg == '0);
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .en    (commit && !commit_err),
        .we    (commit_we),
        .be    (commit_be),
        .addr  (commit_idx),
        .wdata (commit_wdata),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            we_reg      <= 1'b0;
            idx_reg     <= '0;
            wdata_reg   <= '0;
            be_reg      <= '0;
            req_err_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        we_reg      <= req_in.we;
                        idx_reg     <= req_in.addr[AW+1:2];
                        wdata_reg   <= req_in.wdata;
                        be_reg      <= req_in.be;
                        req_err_reg <= req_in_err;
                        if (LATENCY == 0) begin
                            state_reg <= RESP;
                        end else begin
                            state_reg <= WAIT;
                            cnt_reg   <= CNT_W'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt_reg == '0) begin
                        state_reg <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // The array's read register is the data holding register; load_ok_reg gates it to zero for stores and errors.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_err_reg <= 1'b0;
            load_ok_reg <= 1'b0;
        end else if (commit) begin
            rsp_err_reg <= commit_err;
            load_ok_reg <= !commit_we && !commit_err;
        end else if (rsp_fire) begin
            rsp_err_reg <= 1'b0;
            load_ok_reg <= 1'b0;
        end
    end

    assign req_ready_o = (state_reg == IDLE);
    assign rsp_valid_o = (state_reg == RESP);
    assign rsp_err_o   = rsp_err_reg;
    assign rsp_rdata_o = load_ok_reg ? ram_q : '0;

`ifdef DMEM_RSP_PERF_EN
    logic [XLEN-1:0] rd_cnt_reg;
    logic [XLEN-1:0] wr_cnt_reg;
    logic [XLEN-1:0] err_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt_reg  <= '0;
            wr_cnt_reg  <= '0;
            err_cnt_reg <= '0;
        end else if (rsp_fire) begin
            if (rsp_err_reg) begin
                err_cnt_reg <= err_cnt_reg + 1'b1;
            end else if (we_reg) begin
                wr_cnt_reg <= wr_cnt_reg + 1'b1;
            end else begin
                rd_cnt_reg <= rd_cnt_reg + 1'b1;
            end
        end
    end

    assign rd_cnt_o  = rd_cnt_reg;
    assign wr_cnt_o  = wr_cnt_reg;
    assign err_cnt_o = err_cnt_reg;
`endif

endmodule
